// File: rtl/bg_pixel_fetcher.sv
// Background layer fetcher: streams one SDRAM word per active pixel through a
// prefetch FIFO, restarting on each vsync rising edge.
module bg_pixel_fetcher #(
  parameter int ADDR_W    = 25,
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 8,
  parameter int ADDR_STEP = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              ce_pix,
  input  logic              hblank,
  input  logic              vblank,
  input  logic              vs,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] frame_words,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [DATA_W-1:0] pix_out,
  output logic [15:0]       underflow_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, DRAIN, DONE} state_t;

  state_t            state, next_state;
  logic              old_vs;
  logic              limited;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] remain;
  logic [DATA_W-1:0] fifo_mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              restart, active, can_issue;
  logic              issue, push, pop, flush;

  assign restart   = vs & ~old_vs;
  assign active    = ce_pix & ~(hblank | vblank);
  // Only one read is ever outstanding, so count < DEPTH reserves its slot.
  assign can_issue = (count < CNT_W'(DEPTH)) && (!limited || remain != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      old_vs <= 1'b0;
    end else begin
      state  <= next_state;
      old_vs <= vs;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (enable && restart) next_state = FETCH;
      FETCH: begin
        if (!enable)                          next_state = IDLE;
        else if (restart)                     next_state = FETCH;
        else if (can_issue)                   next_state = WAIT;
        else if (limited && remain == '0)     next_state = DONE;
      end
      // A restart racing the completion strobe treats that read as finished.
      WAIT: begin
        if (mem_ready)                next_state = enable ? FETCH : IDLE;
        else if (!enable || restart)  next_state = DRAIN;
      end
      DRAIN: if (mem_ready) next_state = enable ? FETCH : IDLE;
      DONE: begin
        if (!enable)      next_state = IDLE;
        else if (restart) next_state = FETCH;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    flush = ~enable | restart;
    issue = enable & ~restart & (state == FETCH) & can_issue;
    push  = enable & ~restart & (state == WAIT) & mem_ready;
    pop   = enable & active & (count != '0);
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_dout;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr          <= '0;
      remain        <= '0;
      limited       <= 1'b0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      mem_rd        <= 1'b0;
      mem_addr      <= '0;
      pix_out       <= '0;
      underflow_cnt <= '0;
    end else begin
      mem_rd <= issue;
      if (issue) mem_addr <= addr;

      if (restart) begin
        addr    <= base_addr;
        remain  <= frame_words;
        limited <= (frame_words != '0);
      end else if (push) begin
        addr <= addr + ADDR_W'(ADDR_STEP);
        if (limited) remain <= remain - ADDR_W'(1);
      end

      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (!push && pop) count <= count - CNT_W'(1);
      end

      // Starved or blanked pixels go transparent rather than repeating stale data.
      if (!enable)     pix_out <= '0;
      else if (ce_pix) pix_out <= pop ? fifo_mem[rd_ptr] : '0;

      if (enable && active && count == '0 && underflow_cnt != 16'hFFFF)
        underflow_cnt <= underflow_cnt + 16'd1;
    end
  end

endmodule
